// File: rtl/mem_write_port.sv
// ============================================================================
// Module   : mem_write_port
// Purpose  : Byte-masked write port and sequential clear engine for a shared array.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_write_port #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic                    clr_start,
    input  logic [DATA_WIDTH-1:0]   clr_value,
    output logic                    busy,
    output logic                    clr_done,
    output logic [CNT_WIDTH-1:0]    wr_count,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int c_DEPTH = 2**ADDR_WIDTH;
    localparam int c_LANES = DATA_WIDTH/8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [DATA_WIDTH-1:0]   r_fill;
    logic                    r_busy;
    logic                    r_done;
    logic [CNT_WIDTH-1:0]    r_count;
    logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];

    logic                    w_wr_fire;

    assign wr_ready  = ~r_busy;
    assign w_wr_fire = wr_valid & ~r_busy;
    assign busy      = r_busy;
    assign clr_done  = r_done;
    assign wr_count  = r_count;
    assign rd_data   = r_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_fill  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_wr_fire && (r_count != {CNT_WIDTH{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (clr_start) begin
                        r_state <= ST_CLEAR;
                        r_busy  <= 1'b1;
                        r_ptr   <= '0;
                        r_fill  <= clr_value;
                    end
                end
                ST_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == {ADDR_WIDTH{1'b1}}) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ptr   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; a reset edge suppresses both clear and host writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_ptr] <= r_fill;
            end else if (w_wr_fire) begin
                for (int i = 0; i < c_LANES; i++) begin
                    if (wr_mask[i]) begin
                        r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_write_port.sv
// ============================================================================
// Module   : tb_mem_write_port
// Purpose  : Directed self-checking bench for mem_write_port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_write_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_mask;
    logic        clr_start;
    logic [15:0] clr_value;
    logic        busy;
    logic        clr_done;
    logic [3:0]  wr_count;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;

    int passed = 0;
    int total  = 0;
    int nbusy;
    int ndone;

    mem_write_port #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(5),
        .CNT_WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .clr_start(clr_start),
        .clr_value(clr_value),
        .busy     (busy),
        .clr_done (clr_done),
        .wr_count (wr_count),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [15:0] exp);
        rd_addr = a;
        #1;
        chk(tag, {16'h0, rd_data}, {16'h0, exp});
    endtask

    // Called one cycle after the clear-start edge; bounded so a stuck engine still ends.
    task automatic run_clear(output int nb, output int nd);
        nb = 0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            nb++;
            tick();
            if (clr_done) nd++;
        end
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        clr_start = 1'b0; clr_value = '0; rd_addr = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_wr_ready", wr_ready, 1);
        chk("reset_clr_done", clr_done, 0);
        chk("reset_wr_count", wr_count, 0);

        // Initial clear to zero
        clr_start = 1'b1; clr_value = 16'h0000;
        tick();
        clr_start = 1'b0;
        run_clear(nbusy, ndone);
        chk("clr0_busy_cycles", nbusy, 32);
        chk("clr0_done_pulses", ndone, 1);
        chk("clr0_done_high", clr_done, 1);
        chk("clr0_ready_with_done", wr_ready, 1);
        tick();
        chk("clr0_done_low", clr_done, 0);
        rd("clr0_rd0", 5'd0, 16'h0000);
        rd("clr0_rd17", 5'd17, 16'h0000);
        rd("clr0_rd31", 5'd31, 16'h0000);
        chk("clr0_count", wr_count, 0);

        // Masked writes
        wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 16'hA55A; wr_mask = 2'b11;
        tick();
        wr_data = 16'hFFFF; wr_mask = 2'b01;
        tick();
        wr_valid = 1'b0;
        rd("mask_rd5", 5'd5, 16'hA5FF);
        chk("mask_count", wr_count, 2);

        // Read-before-write on the same address
        rd_addr = 5'd9;
        wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 16'h1234; wr_mask = 2'b11;
        #1;
        chk("rbw_old", rd_data, 16'h0000);
        tick();
        wr_valid = 1'b0;
        chk("rbw_new", rd_data, 16'h1234);
        chk("rbw_count", wr_count, 3);

        // Write and clear on the same edge; a second write is held through the clear
        wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 16'h7777; wr_mask = 2'b11;
        clr_start = 1'b1; clr_value = 16'hBEEF;
        tick();
        clr_start = 1'b0; clr_value = 16'h0000;
        wr_addr = 5'd7; wr_data = 16'h5151;
        chk("wc_count", wr_count, 4);
        chk("wc_ready_low", wr_ready, 0);
        run_clear(nbusy, ndone);
        chk("wc_busy_cycles", nbusy, 32);
        chk("wc_count_stalled", wr_count, 4);
        chk("wc_ready_back", wr_ready, 1);
        rd("wc_rd7_before", 5'd7, 16'hBEEF);
        tick();
        wr_valid = 1'b0;
        chk("wc_count_after", wr_count, 5);
        rd("wc_rd7_after", 5'd7, 16'h5151);
        rd("wc_rd3", 5'd3, 16'hBEEF);
        rd("wc_rd5", 5'd5, 16'hBEEF);

        // Reset part-way through a clear
        wr_valid = 1'b1; wr_mask = 2'b11;
        wr_addr = 5'd12; wr_data = 16'h1212; tick();
        wr_addr = 5'd31; wr_data = 16'h3131; tick();
        wr_valid = 1'b0;
        clr_start = 1'b1; clr_value = 16'hCCCC;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_ready", wr_ready, 1);
        chk("mid_done", clr_done, 0);
        chk("mid_count", wr_count, 0);
        rd("mid_rd0", 5'd0, 16'hCCCC);
        rd("mid_rd7", 5'd7, 16'hCCCC);
        rd("mid_rd9", 5'd9, 16'hCCCC);
        rd("mid_rd10", 5'd10, 16'hBEEF);
        rd("mid_rd12", 5'd12, 16'h1212);
        rd("mid_rd31", 5'd31, 16'h3131);

        // Zero-mask writes saturate the 4-bit counter
        wr_valid = 1'b1; wr_addr = 5'd12; wr_data = 16'h0000; wr_mask = 2'b00;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_count14", wr_count, 4'hE);
        tick();
        chk("sat_count15", wr_count, 4'hF);
        for (int i = 0; i < 5; i++) tick();
        wr_valid = 1'b0;
        chk("sat_count20", wr_count, 4'hF);
        rd("sat_rd12", 5'd12, 16'h1212);

        // clr_start held high restarts right after clr_done
        clr_start = 1'b1; clr_value = 16'h0F0F;
        tick();
        run_clear(nbusy, ndone);
        chk("hold_busy_cycles", nbusy, 32);
        chk("hold_done", clr_done, 1);
        tick();
        clr_start = 1'b0;
        chk("hold_restart_busy", busy, 1);
        run_clear(nbusy, ndone);
        chk("hold_busy_cycles2", nbusy, 32);
        rd("hold_rd12", 5'd12, 16'h0F0F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
